// File: rtl/cpu_data_mem_responder.sv
// Data-port responder: word-organised SRAM with 1-cycle registered reads plus a 4-word MMIO window
// (cycle counter, store counter, sticky halt). Define RAW_FWD_EN to forward same-edge RAM writes into read data.
module cpu_data_mem_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        halt,
    output logic [7:0]  halt_code,
    output logic        err_misaligned
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0]           memArray_q [DEPTH];
    logic [31:0]           dataOut_q, dataOut_d;
    logic [31:0]           cycleCnt_q;
    logic [31:0]           storeCnt_q;
    logic                  halt_q;
    logic [7:0]            haltCode_q;
    logic                  errMisaligned_q;

    logic                  ramHit;
    logic                  mmioHit;
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [1:0]            regIdx;
    logic                  wrAny;
    logic                  aligned;
    logic                  ramWe;
    logic                  haltWe;
    logic [31:0]           ramWord;
    logic [31:0]           readData;

    assign ramHit  = (data_addr[31:ADDR_WIDTH+2] == '0);
    assign mmioHit = (data_addr[31:4] == MMIO_BASE[31:4]);
    assign wordIdx = data_addr[ADDR_WIDTH+1:2];
    assign regIdx  = data_addr[3:2];
    assign wrAny   = |data_write;
    assign aligned = (data_addr[1:0] == 2'b00);
    assign ramWe   = wrAny && aligned && ramHit;
    assign haltWe  = wrAny && aligned && mmioHit && (regIdx == 2'd2) && data_write[0] && !halt_q;
    assign ramWord = memArray_q[wordIdx];

    // Read mux sees pre-edge state, so counters and halt read back their old values.
    always_comb begin
        readData = 32'h0;
        if (ramHit) begin
            readData = ramWord;
`ifdef RAW_FWD_EN
            if (ramWe) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_write[b]) begin
                        readData[8*b +: 8] = data_in[8*b +: 8];
                    end
                end
            end
`endif
        end else if (mmioHit) begin
            case (regIdx)
                2'd0:    readData = cycleCnt_q;
                2'd1:    readData = storeCnt_q;
                2'd2:    readData = {halt_q, 23'b0, haltCode_q};
                default: readData = 32'h0;
            endcase
        end
        dataOut_d = data_read ? readData : dataOut_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut_q       <= 32'h0;
            cycleCnt_q      <= 32'h0;
            storeCnt_q      <= 32'h0;
            halt_q          <= 1'b0;
            haltCode_q      <= 8'h0;
            errMisaligned_q <= 1'b0;
        end else begin
            dataOut_q  <= dataOut_d;
            cycleCnt_q <= cycleCnt_q + 32'd1;
            if (ramWe) begin
                storeCnt_q <= storeCnt_q + 32'd1;
            end
            if (haltWe) begin
                halt_q     <= 1'b1;
                haltCode_q <= data_in[7:0];
            end
            if (wrAny && !aligned) begin
                errMisaligned_q <= 1'b1;
            end
        end
    end

    // Contents are never cleared; reset only blocks a write landing while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (data_write[b]) begin
                    memArray_q[wordIdx][8*b +: 8] <= data_in[8*b +: 8];
                end
            end
        end
    end

    assign data_out       = dataOut_q;
    assign halt           = halt_q;
    assign halt_code      = haltCode_q;
    assign err_misaligned = errMisaligned_q;

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Bench for cpu_data_mem_responder: directed literal checks plus randomized traffic against a
// behavioural model. Honours RAW_FWD_EN the same way the design does.
module tb_cpu_data_mem_responder;

    localparam logic [31:0] RAM_BYTES = 32'h0001_0000;
    localparam logic [31:0] MMIO      = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dataRead = 1'b0;
    logic [31:0] dataAddr = 32'h0;
    logic [3:0]  dataWrite = 4'h0;
    logic [31:0] dataIn = 32'h0;
    logic [31:0] dataOut;
    logic        haltOut;
    logic [7:0]  haltCodeOut;
    logic        errOut;

    int nCompared = 0;
    int nMismatched = 0;

    cpu_data_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .data_read      (dataRead),
        .data_addr      (dataAddr),
        .data_write     (dataWrite),
        .data_in        (dataIn),
        .data_out       (dataOut),
        .halt           (haltOut),
        .halt_code      (haltCodeOut),
        .err_misaligned (errOut)
    );

    always #5 clk = ~clk;

    logic [31:0] mdlMem [int];
    logic [31:0] mdlCycles, mdlStores, mdlData;
    logic        mdlHalt, mdlErr, mdlKnown;
    logic [7:0]  mdlCode;

    // Reference model: the spec's decode/read/write rules in plain arithmetic.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdlCycles = 0; mdlStores = 0; mdlData = 0;
            mdlHalt = 0; mdlCode = 0; mdlErr = 0; mdlKnown = 1;
        end else begin
            automatic int word = int'(dataAddr >> 2);
            automatic bit isRam = dataAddr < RAM_BYTES;
            automatic bit isMmio = (dataAddr & 32'hFFFF_FFF0) == MMIO;
            automatic int regNo = int'((dataAddr >> 2) & 3);
            automatic bit isWrite = dataWrite != 0;
            automatic bit isAligned = (dataAddr % 4) == 0;
            automatic bit ramStore = isWrite && isAligned && isRam;
            automatic logic [31:0] oldWord = 0;
            automatic bit oldKnown = mdlMem.exists(word);
            if (oldKnown) oldWord = mdlMem[word];
            if (dataRead) begin
                mdlKnown = 1;
                if (isRam) begin
                    mdlData = oldWord;
                    mdlKnown = oldKnown;
`ifdef RAW_FWD_EN
                    if (ramStore) begin
                        for (int b = 0; b < 4; b++)
                            if (dataWrite[b]) mdlData[8*b +: 8] = dataIn[8*b +: 8];
                        mdlKnown = oldKnown || dataWrite == 4'hF;
                    end
`endif
                end else if (isMmio) begin
                    mdlData = regNo == 0 ? mdlCycles : regNo == 1 ? mdlStores :
                              regNo == 2 ? {mdlHalt, 23'b0, mdlCode} : 32'h0;
                end else begin
                    mdlData = 0;
                end
            end
            if (isWrite && !isAligned) mdlErr = 1;
            if (ramStore) begin
                for (int b = 0; b < 4; b++)
                    if (dataWrite[b]) oldWord[8*b +: 8] = dataIn[8*b +: 8];
                if (oldKnown || dataWrite == 4'hF) mdlMem[word] = oldWord;
                mdlStores++;
            end
            if (isWrite && isAligned && isMmio && regNo == 2 && dataWrite[0] && !mdlHalt) begin
                mdlHalt = 1;
                mdlCode = dataIn[7:0];
            end
            mdlCycles++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Continuous comparison against the model, half a cycle after each edge.
    always @(negedge clk) begin
        if (rst) begin
            if (mdlKnown) checkOutput("model data_out", dataOut, mdlData);
            checkOutput("model halt", {31'b0, haltOut}, {31'b0, mdlHalt});
            checkOutput("model halt_code", {24'b0, haltCodeOut}, {24'b0, mdlCode});
            checkOutput("model err_misaligned", {31'b0, errOut}, {31'b0, mdlErr});
        end
    end

    task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din);
        dataRead = rd; dataAddr = addr; dataWrite = we; dataIn = din;
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        applyIdleInputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyIdleInputs();
        dataRead = 0; dataAddr = 0; dataWrite = 0; dataIn = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " data_out"}, dataOut, 32'h0);
        checkOutput({tag, " halt"}, {31'b0, haltOut}, 32'h0);
        checkOutput({tag, " halt_code"}, {24'b0, haltCodeOut}, 32'h0);
        checkOutput({tag, " err_misaligned"}, {31'b0, errOut}, 32'h0);
    endtask

    logic [31:0] ramPool [9];

    initial begin
        #12;
        checkAllZero("reset");
        releaseReset();
        repeat (10) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, MMIO, 0, 0);
        checkOutput("cycle_cnt after 10 edges", dataOut, 32'd10);
        checkOutput("halt idle", {31'b0, haltOut}, 32'h0);
        checkOutput("err idle", {31'b0, errOut}, 32'h0);

        applyStimulus(0, 32'h10, 4'hF, 32'hDEAD_BEEF);
        applyStimulus(0, 32'h10, 4'h1, 32'h0000_0011);
        applyStimulus(1, 32'h10, 0, 0);
        checkOutput("byte-lane merge", dataOut, 32'hDEAD_BE11);
        applyStimulus(1, MMIO + 4, 0, 0);
        checkOutput("store_cnt two", dataOut, 32'd2);

        applyStimulus(0, 32'h20, 4'hF, 32'h0);
        applyStimulus(1, 32'h20, 4'hF, 32'h1234_5678);
`ifdef RAW_FWD_EN
        checkOutput("same-edge read forwarded", dataOut, 32'h1234_5678);
`else
        checkOutput("same-edge read old", dataOut, 32'h0);
`endif
        applyStimulus(1, 32'h20, 0, 0);
        checkOutput("read after write", dataOut, 32'h1234_5678);

        rst = 1'b0;
        #1;
        checkAllZero("second reset");
        releaseReset();
        applyStimulus(0, MMIO + 8, 4'hF, 32'h0000_002A);
        checkOutput("halt set", {31'b0, haltOut}, 32'h1);
        checkOutput("halt_code captured", {24'b0, haltCodeOut}, 32'h2A);
        applyStimulus(0, MMIO + 8, 4'hF, 32'h0000_0055);
        checkOutput("halt_code sticky", {24'b0, haltCodeOut}, 32'h2A);
        applyStimulus(1, MMIO + 8, 0, 0);
        checkOutput("halt register read", dataOut, 32'h8000_002A);

        applyStimulus(0, 32'h12, 4'hF, 32'hFFFF_FFFF);
        checkOutput("misaligned flag", {31'b0, errOut}, 32'h1);
        applyStimulus(1, 32'h10, 0, 0);
        checkOutput("misaligned write dropped", dataOut, 32'hDEAD_BE11);
        applyStimulus(1, MMIO + 4, 0, 0);
        checkOutput("store_cnt after reset", dataOut, 32'd0);

        applyStimulus(1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
        checkOutput("unmapped read", dataOut, 32'h0);
        applyStimulus(1, 32'h0001_0000, 0, 0);
        checkOutput("first unmapped above RAM", dataOut, 32'h0);
        applyStimulus(1, MMIO + 4, 0, 0);
        checkOutput("unmapped write not counted", dataOut, 32'd0);

        for (int i = 0; i < 8; i++) ramPool[i] = 32'(i * 4);
        ramPool[8] = RAM_BYTES - 4;
        foreach (ramPool[i]) applyStimulus(0, ramPool[i], 4'hF, $urandom);
        for (int n = 0; n < 400; n++) begin
            automatic int pick = $urandom_range(0, 99);
            automatic logic [31:0] addr;
            automatic logic [3:0] we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if (pick < 60) addr = ramPool[$urandom_range(0, 8)];
            else if (pick < 85) addr = MMIO + 32'($urandom_range(0, 3) * 4);
            else if (pick < 92) addr = RAM_BYTES;
            else addr = 32'h8000_0000 | (32'($urandom) & 32'h7FFF_FFFC);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            applyStimulus($urandom_range(0, 9) < 7, addr, we, $urandom);
        end

        applyStimulus(0, 32'h20, 4'hF, 32'h5A5A_5A5A);
        applyStimulus(1, 32'h20, 0, 0);
        dataAddr = 32'h20; dataWrite = 4'hF; dataIn = 32'hCAFE_F00D; dataRead = 0;
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("mid-write reset");
        @(posedge clk);
        #1;
        releaseReset();
        applyStimulus(1, 32'h20, 0, 0);
        checkOutput("write lost in reset", dataOut, 32'h5A5A_5A5A);
        applyStimulus(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
